sum_cmp_det_pipe: RTL and testbench
===================================

Name: sum_cmp_det_pipe

Overview:
- Pipelined, handshaked successor to the constant-time sum-zero detector.
- Flags whether A+B+CI (mod 2^width) equals a selectable target (zero, all-ones, or operand C), or whether A==B. It never forms the sum.
- Sits beside adders and ALUs to deliver early compare/branch flags.
- Also keeps a saturating match counter and a sticky all-match flag for streaming use.

Parameters:
- width, 8: operand word width (>=2).
- stages, 2: pipeline register stages (1..4); equals the input-to-output latency.
- cntw, 8: width of the match counter (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  input transaction valid
- ready_o  out  1  block can accept input
- A_i  in  width  operand A
- B_i  in  width  operand B
- C_i  in  width  compare target (used only in mode 2)
- CI_i  in  1  carry in (ignored in mode 3)
- mode_i  in  2  0: sum==0, 1: sum==all-ones, 2: sum==C_i, 3: A_i==B_i
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- Z_o  out  1  match flag for the transaction at the output
- clear_i  in  1  synchronous clear of counter and sticky flag
- match_cnt_o  out  cntw  saturating count of delivered matches
- all_match_o  out  1  sticky AND of all delivered Z_o since reset or clear

Behaviour:
- Flag math, modes 0-2. Target T is 0, all-ones or C_i.
  - Let D = ~T.
  - S[i] = A^B^D.
  - K[i] = maj(A,B,D).
  - Carry vector Y = {K[width-2:0], CI}.
  - Match iff (S ^ Y) is all-ones, i.e. AND over bits of ~(S[i]^Y[i]^1)... equivalently f[i] = S[i]^Y[i] and Z = &f.
- Flag math, mode 3: f[i] = ~(A[i]^B[i]). CI is ignored.
- Z must equal the behavioural ((A+B+CI) mod 2^width == T), or A==B in mode 3, for all inputs.
- Pipeline structure:
  - Stage 1 registers the width-bit vector f.
  - Later stages register partial AND reductions; group split is free.
  - With stages=1, the single register holds f and the final AND is combinational to Z_o.
- Latency: a transaction accepted at edge n appears on valid_o/Z_o after edge n+stages-1, presented in the cycle following edge n+stages-1, if never stalled.
- Throughput: 1 per cycle.
- Handshake:
  - Input transfer on valid_i&&ready_o; output transfer on valid_o&&ready_i.
  - Each stage advances when its successor is empty or advancing.
  - ready_o = stage1 empty or stage1 advancing.
  - Under stall, valid_o and Z_o are held stable until accepted.
  - No transaction is dropped or duplicated. Order is preserved.
- Counter and sticky flag:
  - On each output transfer with Z_o=1, match_cnt_o increments, saturating at 2^cntw-1 (holds, no wrap).
  - On each output transfer with Z_o=0, all_match_o drops to 0 and stays there until clear/reset.
  - clear_i sets match_cnt_o=0 and all_match_o=1. If clear_i coincides with an output transfer, clear wins and that transfer is not counted.
  - clear_i does not affect the pipeline contents or the handshake.
- Reset (async, any time including mid-stream):
  - All stage valids=0, so valid_o=0.
  - Z_o=0, match_cnt_o=0, all_match_o=1, ready_o=1.
  - In-flight transactions are discarded. The first edge after deassertion may accept input.
- Data registers need no reset; only valids, counter and sticky flag are reset.

Test Plan:
- width=8, stages=2, ready_i=1, mode 0:
  - A=0x7F, B=0x80, CI=1 -> Z_o=1 exactly 2 cycles after acceptance.
  - A=0x7F, B=0x80, CI=0 -> Z_o=0.
  - match_cnt_o=1, all_match_o=0.
- Modes 1/2/3, back-to-back, one per cycle:
  - mode1 A=0x0F, B=0xF0, CI=0 -> 1.
  - mode2 A=0x10, B=0x20, CI=1, C=0x31 -> 1.
  - mode2 same operands with C=0x30 -> 0.
  - mode3 A=B=0xA5, CI=1 -> 1.
  - Required: outputs in order on consecutive cycles.
- Backpressure:
  - Stream 6 mode-0 matches with ready_i held 0 for 4 cycles mid-stream.
  - valid_o/Z_o stable while stalled; ready_o drops once full.
  - All 6 results delivered; match_cnt_o=6.
- Saturation and clear, cntw=2:
  - 5 matches -> match_cnt_o=3.
  - clear_i asserted on the cycle of a 6th match transfer -> match_cnt_o=0, all_match_o=1.
- Reset mid-stream: assert rst_i with 2 transactions in flight -> valid_o=0 immediately, no stale result after release.
- Random: 10k random A/B/C/CI/mode with random ready_i/valid_i across stages 1..4 and width 2/8/33 -> every Z_o equals the behavioural reference model.

Source files
------------

// File: rtl/sum_cmp_det_pipe.sv
// Pipelined valid/ready flag unit: (A+B+CI) == target or A == B, without an adder.
// Also tracks a saturating match count and a sticky all-match flag.
module sum_cmp_det_pipe #(
  parameter int width  = 8,
  parameter int stages = 2,
  parameter int cntw   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] A_i,
  input  logic [width-1:0] B_i,
  input  logic [width-1:0] C_i,
  input  logic             CI_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             Z_o,
  input  logic             clear_i,
  output logic [cntw-1:0]  match_cnt_o,
  output logic             all_match_o
);

  logic [width-1:0] w_t;
  logic [width-1:0] w_d;
  logic [width-1:0] w_s;
  logic [width-1:0] w_k;
  logic [width-1:0] w_y;
  logic [width-1:0] w_f;

  logic [stages:1]  r_v;
  logic [stages:1]  w_adv;
  logic [stages:1]  w_ld;
  logic [width-1:0] r_d  [1:stages];
  logic [width-1:0] w_nx [1:stages];

  logic [cntw-1:0]  r_cnt;
  logic             r_all;
  logic             w_xfer;

  // Pairwise AND; unused upper bits pad with ones so &result == &v.
  function automatic logic [width-1:0] f_pair(
    input logic [width-1:0] v
  );
    logic [width-1:0] r;
    r = '1;
    for (int i = 0; i < width / 2; i++) begin
      r[i] = v[2*i] & v[2*i+1];
    end
    if (width % 2 != 0) begin
      r[width/2] = v[width-1];
    end
    return r;
  endfunction

  // Match iff the carry-save form of A+B+~T+CI is all-ones.
  always_comb begin
    w_t = '0;
    unique case (mode_i)
      2'd1:    w_t = '1;
      2'd2:    w_t = C_i;
      default: w_t = '0;
    endcase
    w_d = ~w_t;
    w_s = A_i ^ B_i ^ w_d;
    w_k = (A_i & B_i) | (A_i & w_d) | (B_i & w_d);
    w_y = {w_k[width-2:0], CI_i};
    if (mode_i == 2'd3) begin
      w_f = ~(A_i ^ B_i);
    end else begin
      w_f = w_s ^ w_y;
    end
  end

  always_comb begin
    logic go;
    w_adv = '0;
    w_ld  = '0;
    go    = ready_i;
    for (int s = stages; s >= 1; s--) begin
      w_adv[s] = r_v[s] & go;
      go       = ~r_v[s] | w_adv[s];
    end
    ready_o = go;
    w_ld[1] = valid_i & go;
    for (int s = 2; s <= stages; s++) begin
      w_ld[s] = w_adv[s-1];
    end
  end

  always_comb begin
    w_nx[1] = w_f;
    for (int s = 2; s <= stages; s++) begin
      w_nx[s] = f_pair(r_d[s-1]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v <= '0;
    end else begin
      for (int s = 1; s <= stages; s++) begin
        if (w_ld[s]) begin
          r_v[s] <= 1'b1;
        end else if (w_adv[s]) begin
          r_v[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 1; s <= stages; s++) begin
      if (w_ld[s]) begin
        r_d[s] <= w_nx[s];
      end
    end
  end

  assign valid_o = r_v[stages];
  assign Z_o     = r_v[stages] & (&r_d[stages]);
  assign w_xfer  = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_all <= 1'b1;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_all <= 1'b1;
    end else if (w_xfer) begin
      if (Z_o) begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + cntw'(1);
        end
      end else begin
        r_all <= 1'b0;
      end
    end
  end

  assign match_cnt_o = r_cnt;
  assign all_match_o = r_all;

endmodule

// File: tb/tb_sum_cmp_det_pipe.sv
// Bench for sum_cmp_det_pipe: directed scenarios plus random traffic
// over several width/stage configurations against an arithmetic model.
module tb_sum_cmp_det_pipe;

  logic        clk;
  logic        rst;
  logic        vin;
  logic        rdy;
  logic        clr;
  logic        ci;
  logic [1:0]  md;
  logic [32:0] A;
  logic [32:0] B;
  logic [32:0] C;

  logic        vo [5];
  logic        zo [5];
  logic        ro [5];
  logic        am [5];
  logic [7:0]  cnt [4];
  logic [1:0]  cnt_s;

  int n_tests;
  int n_fail;

  logic expq [5][16384];
  int   hd [5];
  int   tl [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 33);
    sum_cmp_det_pipe #(.width(W), .stages(g + 1), .cntw(8)) u_dut (
      .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(ro[g]),
      .A_i(A[W-1:0]), .B_i(B[W-1:0]), .C_i(C[W-1:0]), .CI_i(ci),
      .mode_i(md), .valid_o(vo[g]), .ready_i(rdy), .Z_o(zo[g]),
      .clear_i(clr), .match_cnt_o(cnt[g]), .all_match_o(am[g])
    );
  end

  sum_cmp_det_pipe #(.width(8), .stages(2), .cntw(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(ro[4]),
    .A_i(A[7:0]), .B_i(B[7:0]), .C_i(C[7:0]), .CI_i(ci),
    .mode_i(md), .valid_o(vo[4]), .ready_i(rdy), .Z_o(zo[4]),
    .clear_i(clr), .match_cnt_o(cnt_s), .all_match_o(am[4])
  );

  function automatic int wid(int k);
    if (k == 0) return 2;
    if (k == 1 || k == 4) return 8;
    return 33;
  endfunction

  function automatic logic ref_z(int w, logic [32:0] a, logic [32:0] b,
                                 logic [32:0] c, logic cin, logic [1:0] m);
    logic [63:0] mk, s, t;
    mk = (64'd1 << w) - 64'd1;
    if (m == 2'd3) return (({31'd0, a} ^ {31'd0, b}) & mk) == 64'd0;
    s = ({31'd0, a} + {31'd0, b} + {63'd0, cin}) & mk;
    if (m == 2'd0) t = 64'd0;
    else if (m == 2'd1) t = mk;
    else t = {31'd0, c} & mk;
    return s == t;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; vin = 0; clr = 0;
    tick();
    rst = 0;
  endtask

  task automatic set_match();
    A  = {1'($urandom), 32'($urandom)};
    ci = 1'($urandom);
    md = 2'd0;
    B  = 33'd0 - A - {32'd0, ci};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; vin = 0;
    #1;
    n_tests++; if (vo[1] !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", vo[1]); end
    n_tests++; if (zo[1] !== 1'b0) begin n_fail++; $display("FAIL rst_z got %b want 0", zo[1]); end
    n_tests++; if (cnt[1] !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", cnt[1]); end
    n_tests++; if (am[1] !== 1'b1) begin n_fail++; $display("FAIL rst_all got %b want 1", am[1]); end
    n_tests++; if (ro[1] !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", ro[1]); end
    tick();
    rst = 0;
  endtask

  task automatic test_mode0();
    md = 2'd0; A = 33'h7F; B = 33'h80; ci = 1; vin = 1; rdy = 1;
    tick();
    ci = 0;
    #1;
    n_tests++; if (vo[1] !== 1'b0) begin n_fail++; $display("FAIL m0_early got %b want 0", vo[1]); end
    tick();
    vin = 0;
    #1;
    n_tests++; if ({vo[1], zo[1]} !== 2'b11) begin n_fail++; $display("FAIL m0_match got %b want 11", {vo[1], zo[1]}); end
    tick();
    n_tests++; if ({vo[1], zo[1]} !== 2'b10) begin n_fail++; $display("FAIL m0_nomatch got %b want 10", {vo[1], zo[1]}); end
    tick();
    n_tests++; if (vo[1] !== 1'b0) begin n_fail++; $display("FAIL m0_drain got %b want 0", vo[1]); end
    n_tests++; if (cnt[1] !== 8'd1) begin n_fail++; $display("FAIL m0_cnt got %0d want 1", cnt[1]); end
    n_tests++; if (am[1] !== 1'b0) begin n_fail++; $display("FAIL m0_all got %b want 0", am[1]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ex;
    ex = 4'b1011;
    rdy = 1;
    for (int i = 0; i < 6; i++) begin
      vin = (i < 4);
      case (i)
        0: begin md = 2'd1; A = 33'h0F; B = 33'hF0; ci = 0; end
        1: begin md = 2'd2; A = 33'h10; B = 33'h20; ci = 1; C = 33'h31; end
        2: begin C = 33'h30; end
        3: begin md = 2'd3; A = 33'hA5; B = 33'hA5; ci = 1; end
        default: ;
      endcase
      #1;
      if (i >= 2) begin
        n_tests++;
        if ({vo[1], zo[1]} !== {1'b1, ex[i-2]}) begin
          n_fail++; $display("FAIL b2b_%0d got %b want %b", i - 2, {vo[1], zo[1]}, {1'b1, ex[i-2]});
        end
      end
      tick();
    end
    n_tests++; if (vo[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", vo[1]); end
  endtask

  task automatic test_backpressure();
    int sent, got, cyc;
    logic pv, pz, low;
    sent = 0; got = 0; cyc = 0; pv = 0; pz = 0; low = 0;
    do_reset();
    while (got < 6 && cyc < 40) begin
      vin = (sent < 6);
      if (vin) set_match();
      rdy = !(cyc >= 3 && cyc < 7);
      #1;
      if (pv) begin
        n_tests++;
        if ({vo[1], zo[1]} !== {1'b1, pz}) begin
          n_fail++; $display("FAIL bp_hold got %b want %b", {vo[1], zo[1]}, {1'b1, pz});
        end
      end
      if (!ro[1]) low = 1;
      if (vo[1] && rdy) begin
        got++;
        n_tests++; if (zo[1] !== 1'b1) begin n_fail++; $display("FAIL bp_z got %b want 1", zo[1]); end
      end
      if (vin && ro[1]) sent++;
      pv = vo[1] && !rdy;
      pz = zo[1];
      tick();
      cyc++;
    end
    vin = 0; rdy = 1;
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", got); end
    n_tests++; if (low !== 1'b1) begin n_fail++; $display("FAIL bp_ready_drop got %b want 1", low); end
    n_tests++; if (cnt[1] !== 8'd6) begin n_fail++; $display("FAIL bp_cnt got %0d want 6", cnt[1]); end
    n_tests++; if (am[1] !== 1'b1) begin n_fail++; $display("FAIL bp_all got %b want 1", am[1]); end
  endtask

  task automatic test_sat_clear();
    int k;
    do_reset();
    rdy = 1;
    for (int i = 0; i < 5; i++) begin
      vin = 1; set_match();
      tick();
    end
    vin = 0;
    repeat (3) tick();
    n_tests++; if (cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d want 3", cnt_s); end
    n_tests++; if (am[4] !== 1'b1) begin n_fail++; $display("FAIL sat_all got %b want 1", am[4]); end
    vin = 1; set_match();
    tick();
    vin = 0;
    k = 0;
    while (!vo[4] && k < 5) begin tick(); k++; end
    n_tests++; if ({vo[4], zo[4]} !== 2'b11) begin n_fail++; $display("FAIL clr_arrive got %b want 11", {vo[4], zo[4]}); end
    clr = 1;
    tick();
    clr = 0;
    #1;
    n_tests++; if (cnt_s !== 2'd0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", cnt_s); end
    n_tests++; if (am[4] !== 1'b1) begin n_fail++; $display("FAIL clr_all got %b want 1", am[4]); end
    n_tests++; if (vo[4] !== 1'b0) begin n_fail++; $display("FAIL clr_nodup got %b want 0", vo[4]); end
    vin = 1; set_match();
    tick();
    vin = 0;
    repeat (3) tick();
    n_tests++; if (cnt_s !== 2'd1) begin n_fail++; $display("FAIL clr_recount got %0d want 1", cnt_s); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy = 1;
    vin = 1; set_match(); tick();
    set_match(); tick();
    vin = 0;
    #1;
    n_tests++; if (vo[1] !== 1'b1) begin n_fail++; $display("FAIL rmid_inflight got %b want 1", vo[1]); end
    rst = 1;
    #1;
    n_tests++; if (vo[1] !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", vo[1]); end
    n_tests++; if (zo[1] !== 1'b0) begin n_fail++; $display("FAIL rmid_z got %b want 0", zo[1]); end
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (vo[1] !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_%0d got %b want 0", i, vo[1]); end
      tick();
    end
  endtask

  task automatic pop_push();
    for (int k = 0; k < 5; k++) begin
      if (vo[k] && rdy) begin
        n_tests++;
        if (hd[k] == tl[k]) begin
          n_fail++; $display("FAIL rand_extra dut%0d got %b want none", k, zo[k]);
        end else begin
          if (zo[k] !== expq[k][hd[k]]) begin
            n_fail++; $display("FAIL rand_z dut%0d idx%0d got %b want %b", k, hd[k], zo[k], expq[k][hd[k]]);
          end
          hd[k]++;
        end
      end
      if (vin && ro[k]) begin
        expq[k][tl[k]] = ref_z(wid(k), A, B, C, ci, md);
        tl[k]++;
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] t;
    do_reset();
    for (int k = 0; k < 5; k++) begin hd[k] = 0; tl[k] = 0; end
    for (int c = 0; c < 10000; c++) begin
      A  = {1'($urandom), 32'($urandom)};
      C  = {1'($urandom), 32'($urandom)};
      md = 2'($urandom);
      ci = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (md == 2'd0) t = 33'd0;
        else if (md == 2'd1) t = '1;
        else t = C;
        B = (md == 2'd3) ? A : (t - A - {32'd0, ci});
      end else begin
        B = {1'($urandom), 32'($urandom)};
      end
      vin = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      pop_push();
      tick();
    end
    vin = 0; rdy = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      pop_push();
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (hd[k] != tl[k]) begin
        n_fail++; $display("FAIL rand_drain dut%0d got %0d want %0d", k, hd[k], tl[k]);
      end
    end
  endtask

  initial begin
    clk = 0; rst = 0; vin = 0; rdy = 1; clr = 0; ci = 0; md = 0;
    A = '0; B = '0; C = '0;
    n_tests = 0; n_fail = 0;
    test_reset();
    test_mode0();
    test_back_to_back();
    test_backpressure();
    test_sat_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
